// File: rtl/register_loader.sv
// Byte-stream register image loader: packs little-endian bytes into words and issues one write per word.
// Optional trailing XOR checksum byte is enabled by defining REGISTER_LOADER_CHECKSUM_EN.
module register_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] firstAddress,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic [7:0]            byteIn,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic [ADDR_WIDTH-1:0] writeAddress,
  output logic                  writeRegister,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
`ifdef REGISTER_LOADER_CHECKSUM_EN
    CHECK,
`endif
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  write_reg_q;
  logic                  busy_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] lane_word;
  logic                  take;

  // byte_ready_q is the registered copy of byteReady, so a transfer is judged on it
  assign take = byteValid & byte_ready_q;

  // Word as it looks with the incoming byte dropped into its lane
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
    assign lane_word[8*gi +: 8] = (idx_q == IDX_W'(gi)) ? byteIn : word_q[8*gi +: 8];
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    idx_d        = idx_q;
    word_d       = word_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = firstAddress;
          remaining_d = count;
          idx_d       = '0;
          state_d     = (count == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        if (take) begin
          word_d = lane_word;
          if (idx_q == LAST_IDX) begin
            idx_d        = '0;
            write_addr_d = addr_q;
            write_data_d = lane_word;
            state_d      = WRITE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      WRITE: begin
        addr_d      = addr_q + ADDR_WIDTH'(1);
        remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
        if (remaining_q == (ADDR_WIDTH+1)'(1)) begin
`ifdef REGISTER_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = COLLECT;
        end
      end
`ifdef REGISTER_LOADER_CHECKSUM_EN
      CHECK: begin
        if (take) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    byte_ready_d = (state_d == COLLECT);
`ifdef REGISTER_LOADER_CHECKSUM_EN
    byte_ready_d = byte_ready_d | (state_d == CHECK);
`endif
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
      byte_ready_q <= 1'b0;
      write_reg_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      byte_ready_q <= byte_ready_d;
      write_reg_q  <= (state_d == WRITE);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
    end
  end

`ifdef REGISTER_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       error_q, error_d;

  always_comb begin
    csum_d  = csum_q;
    error_d = error_q;
    if (state_q == IDLE && start) begin
      csum_d  = '0;
      error_d = 1'b0;
    end else if (state_q == COLLECT && take) begin
      csum_d = csum_q ^ byteIn;
    end else if (state_q == CHECK && take && byteIn != csum_q) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum_q  <= '0;
      error_q <= 1'b0;
    end else begin
      csum_q  <= csum_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign byteReady     = byte_ready_q;
  assign writeAddress  = write_addr_q;
  assign writeRegister = write_reg_q;
  assign writeData     = write_data_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_register_loader.sv
// Randomized bench for register_loader: streams word images and compares the write trace to a list model.
module tb_register_loader;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NB = DW / 8;
  localparam int NREG = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] firstAddress = '0;
  logic [AW:0]   count = '0;
  logic [7:0]    byteIn = '0;
  logic          byteValid = 1'b0;
  logic          byteReady;
  logic [AW-1:0] writeAddress;
  logic          writeRegister;
  logic [DW-1:0] writeData;
  logic          busy;
  logic          done;
  logic          error;

  register_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .start(start), .firstAddress(firstAddress),
    .count(count), .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
    .writeAddress(writeAddress), .writeRegister(writeRegister), .writeData(writeData),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } wr_t;

  wr_t           wr_q[$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            ready_cnt = 0;
  logic [DW-1:0] words_q[$];

  // Trace observer: every write, done pulse and ready cycle, sampled mid-cycle
  always @(negedge clock) begin
    if (writeRegister) wr_q.push_back('{writeAddress, writeData, cyc});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (byteReady) ready_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic run_load(input logic [AW-1:0] fa, input int n, input bit gaps,
                          input bit noise, input logic [7:0] csum_xor);
    logic [7:0]    bytes[$];
    int            last_acc[$];
    logic [7:0]    x;
    logic [DW-1:0] w;
    int            sent, guard, base_wr, base_done, nb, start_cyc, csum_cyc, exp_done;
    logic          err_exp;
    wr_t           e;
    x = '0;
    csum_cyc = 0;
    for (int i = 0; i < n; i++) begin
      w = words_q[i];
      for (int k = 0; k < NB; k++) begin
        bytes.push_back(w[8*k +: 8]);
        x ^= w[8*k +: 8];
      end
    end
    err_exp = 1'b0;
`ifdef REGISTER_LOADER_CHECKSUM_EN
    if (n > 0) begin
      bytes.push_back(x ^ csum_xor);
      err_exp = (csum_xor != 8'h00);
    end
`endif
    nb = bytes.size();
    base_wr = wr_q.size();
    base_done = done_cnt;

    @(negedge clock);
    start = 1'b1;
    firstAddress = fa;
    count = (AW+1)'(n);
    start_cyc = cyc;
    @(negedge clock);
    start = 1'b0;
    check("busy_rise", busy, 1);
    if (n == 0) check("done_zero_next", done, 1);

    sent = 0;
    guard = 0;
    while (sent < nb && guard < 5000) begin
      guard++;
      if (noise) begin
        start = ($urandom_range(0, 3) == 0);
        firstAddress = AW'($urandom);
        count = (AW+1)'($urandom_range(0, NREG));
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        byteValid = 1'b0;
      end else begin
        byteValid = 1'b1;
        byteIn = bytes[sent];
      end
      if (byteValid && byteReady) begin
        if (sent < n * NB && (sent % NB) == NB - 1) last_acc.push_back(cyc);
        if (sent == n * NB) csum_cyc = cyc;
        sent++;
      end
      @(negedge clock);
    end
    byteValid = 1'b0;
    start = 1'b0;
    check("stream_in_time", guard < 5000, 1);

    guard = 0;
    while (done_cnt == base_done && guard < 100) begin
      @(posedge clock);
      guard++;
    end
    check("done_count", done_cnt - base_done, 1);
    @(negedge clock);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);

    check("n_writes", wr_q.size() - base_wr, n);
    for (int i = 0; i < n && base_wr + i < wr_q.size(); i++) begin
      e = wr_q[base_wr + i];
      check("wr_addr", e.a, (int'(fa) + i) % NREG);
      check("wr_data", e.d, words_q[i]);
      if (i < last_acc.size()) check("wr_latency", e.c, last_acc[i] + 1);
    end
    if (n == 0) exp_done = start_cyc + 1;
`ifdef REGISTER_LOADER_CHECKSUM_EN
    else exp_done = csum_cyc + 1;
`else
    else exp_done = last_acc[n-1] + 2;
`endif
    check("done_time", done_cyc, exp_done);
    check("error", error, err_exp);
  endtask

  initial begin
    int rc, base;
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc, base;
    repeat (3) @(negedge clock);
    check("rst_byteReady", byteReady, 0);
    check("rst_writeRegister", writeRegister, 0);
    check("rst_writeAddress", writeAddress, 0);
    check("rst_writeData", writeData, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    words_q = {32'h12345678};
    run_load(5'd2, 1, 1'b0, 1'b0, 8'h00);

    words_q = {$urandom, $urandom, $urandom};
    run_load(5'd30, 3, 1'b0, 1'b0, 8'h00);

    rc = ready_cnt;
    run_load(5'd7, 0, 1'b0, 1'b0, 8'h00);
    check("zero_no_ready", ready_cnt - rc, 0);

    words_q = {$urandom, $urandom, $urandom, $urandom};
    run_load(5'd10, 4, 1'b0, 1'b0, 8'h00);
    run_load(5'd10, 4, 1'b1, 1'b1, 8'h00);

    // Reset two bytes into the first word
    words_q = {$urandom, $urandom};
    base = wr_q.size();
    @(negedge clock);
    start = 1'b1;
    firstAddress = 5'd5;
    count = 6'd2;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      byteValid = 1'b1;
      byteIn = 8'(i + 8'hA0);
      @(negedge clock);
    end
    byteValid = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_byteReady", byteReady, 0);
    check("mid_rst_writeRegister", writeRegister, 0);
    check("mid_rst_writeAddress", writeAddress, 0);
    check("mid_rst_writeData", writeData, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_error", error, 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("mid_rst_no_write", wr_q.size() - base, 0);
    check("mid_rst_idle", busy, 0);
    run_load(5'd3, 2, 1'b1, 1'b0, 8'h00);

    words_q = {32'h08040201};
    run_load(5'd0, 1, 1'b0, 1'b0, 8'h00);
    run_load(5'd0, 1, 1'b0, 1'b0, 8'h0F);
    run_load(5'd1, 1, 1'b0, 1'b0, 8'h00);

    for (int t = 0; t < 4; t++) begin
      int n;
      n = $urandom_range(1, 5);
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      run_load(AW'($urandom), n, 1'($urandom), 1'($urandom), 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
